// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder: receive side of a scanned 8-digit 7-segment display bus.
// Synchronises the active-low select/segment bus, waits for it to settle,
// decodes the selected digit's segment pattern to a hex nibble and assembles
// the eight nibbles and decimal points into a 32-bit word.
module ss_scan_decoder #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ss_value,
    input  logic [7:0]  ss_select,
    output logic [31:0] bcd,
    output logic [7:0]  dots,
    output logic [7:0]  digit_seen,
    output logic        frame_done,
    output logic        pattern_err,
    output logic        select_err
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);

    // {select_n, dp_n, seg_n}; all-ones is the idle bus
    logic [15:0]   sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture;

    logic [31:0] bcd_q, bcd_d;
    logic [7:0]  dots_q, dots_d;
    logic [7:0]  seen_q, seen_d, seen_merge;
    logic        frame_q, frame_d;
    logic        pat_err_q, pat_err_d;
    logic        sel_err_q, sel_err_d;

    logic [7:0]  sel;
    logic [6:0]  pat;
    logic        dp_lit;
    logic        one_hot;
    logic        nib_valid;
    logic [3:0]  nib;
    logic [7:0]  digit_wr;
    logic        valid_cap;

    // two-flop synchroniser plus a copy of the previous sample for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 16'hFFFF;
            sync2_q <= 16'hFFFF;
            prev_q  <= 16'hFFFF;
        end else begin
            sync1_q <= {ss_select, ss_value};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // stability counter: restart at 1 on change, count up to SETTLE, strobe on arrival
    always_comb begin
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (sync2_q != prev_q) begin
            cnt_d   = CW'(1);
            capture = (SETTLE_CYCLES == 1);
        end else if (cnt_q < SETTLE_C) begin
            cnt_d   = cnt_q + CW'(1);
            capture = ((cnt_q + CW'(1)) == SETTLE_C);
        end
    end

    // stability counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sel     = ~sync2_q[15:8];
    assign dp_lit  = ~sync2_q[7];
    assign pat     = ~sync2_q[6:0];
    assign one_hot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);

    // segment pattern (gfedcba, active-high) to hex nibble
    always_comb begin
        nib_valid = 1'b1;
        nib       = 4'h0;
        case (pat)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: nib_valid = 1'b0;
        endcase
    end

    assign valid_cap = capture && one_hot && nib_valid;

    // per-digit write enables and next nibble/dot
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_wr[gi]         = valid_cap && sel[gi];
            assign bcd_d[gi*4 +: 4]     = digit_wr[gi] ? nib : bcd_q[gi*4 +: 4];
            assign dots_d[gi]           = digit_wr[gi] ? dp_lit : dots_q[gi];
        end
    endgenerate

    // frame bookkeeping and error pulses
    always_comb begin
        seen_merge = seen_q | digit_wr;
        seen_d     = seen_merge;
        frame_d    = 1'b0;
        pat_err_d  = capture && one_hot && !nib_valid;
        sel_err_d  = capture && (sel != 8'h00) && !one_hot;
        if (valid_cap && (seen_merge == 8'hFF)) begin
            frame_d = 1'b1;
            seen_d  = 8'h00;
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q     <= '0;
            dots_q    <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            pat_err_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            bcd_q     <= bcd_d;
            dots_q    <= dots_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            pat_err_q <= pat_err_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bcd         = bcd_q;
    assign dots        = dots_q;
    assign digit_seen  = seen_q;
    assign frame_done  = frame_q;
    assign pattern_err = pat_err_q;
    assign select_err  = sel_err_q;
endmodule

// File: tb/tb_ss_scan_decoder.sv
// Bench for ss_scan_decoder: directed scenarios plus random bus segments,
// checked against a segment-level model of the display receiver.
module tb_ss_scan_decoder;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst;
    logic [7:0]  ss_value, ss_select;
    logic [31:0] bcd;
    logic [7:0]  dots, digit_seen;
    logic        frame_done, pattern_err, select_err;

    ss_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .ss_value(ss_value), .ss_select(ss_select),
        .bcd(bcd), .dots(dots), .digit_seen(digit_seen),
        .frame_done(frame_done), .pattern_err(pattern_err), .select_err(select_err)
    );

    always #5 if (clk_en) clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [6:0]  seg_tab [16];
    logic [31:0] m_bcd;
    logic [7:0]  m_dots, m_seen;
    int          m_frame, m_pat, m_sel;
    int          o_frame, o_pat, o_sel;
    logic [15:0] last_in;
    int          run_len;
    int          seg_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int nibble, input bit dp);
        logic [6:0] p;
        p = seg_tab[nibble];
        return {~dp, ~p};
    endfunction

    // effect of one settled bus value on the received display state
    task automatic m_capture(input logic [7:0] sel_n, input logic [7:0] val_n);
        logic [7:0] s;
        logic [6:0] p;
        int k, hit;
        s = ~sel_n;
        p = ~val_n[6:0];
        if (s == 8'h00) return;
        if ($countones(s) != 1) begin
            m_sel++;
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (s[i]) k = i;
        hit = -1;
        for (int i = 0; i < 16; i++) if (seg_tab[i] == p) hit = i;
        if (hit < 0) begin
            m_pat++;
            return;
        end
        m_bcd[k*4 +: 4] = 4'(hit);
        m_dots[k]       = ~val_n[7];
        m_seen[k]       = 1'b1;
        if (m_seen == 8'hFF) begin
            m_frame++;
            m_seen = 8'h00;
        end
    endtask

    // hold one bus value for n clocks, then compare everything with the model
    task automatic drive_seg(input logic [7:0] sel_n, input logic [7:0] val_n, input int n);
        logic [15:0] v;
        int prev_run;
        v = {sel_n, val_n};
        @(negedge clk);
        ss_select = sel_n;
        ss_value  = val_n;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            o_frame += int'(frame_done);
            o_pat   += int'(pattern_err);
            o_sel   += int'(select_err);
        end
        prev_run = (v == last_in) ? run_len : 0;
        run_len  = prev_run + n;
        last_in  = v;
        if (prev_run < SETTLE + 1 && run_len >= SETTLE + 1) m_capture(sel_n, val_n);
        seg_no++;
        $display("seg %0d sel_n=%02h val_n=%02h hold=%0d bcd=%08h seen=%02h",
                 seg_no, sel_n, val_n, n, bcd, digit_seen);
        check_eq("bcd", bcd, m_bcd);
        check_eq("dots", 32'(dots), 32'(m_dots));
        check_eq("digit_seen", 32'(digit_seen), 32'(m_seen));
        check_eq("frame_cnt", o_frame, m_frame);
        check_eq("pattern_cnt", o_pat, m_pat);
        check_eq("select_cnt", o_sel, m_sel);
    endtask

    // asynchronous reset with the clock either running or stopped low
    task automatic do_reset(input bit stop_clk);
        @(negedge clk);
        ss_select = 8'hFF;
        ss_value  = 8'hFF;
        if (stop_clk) clk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_bcd", bcd, 32'h0);
        check_eq("rst_dots", 32'(dots), 32'h0);
        check_eq("rst_seen", 32'(digit_seen), 32'h0);
        check_eq("rst_pulses", {29'h0, frame_done, pattern_err, select_err}, 32'h0);
        #3;
        rst = 1'b0;
        #2;
        clk_en = 1'b1;
        m_bcd = '0; m_dots = '0; m_seen = '0;
        last_in = 16'hFFFF;
        run_len = 1000;
    endtask

    initial begin
        logic [7:0] rs, rv;
        int hold;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_frame = 0; m_pat = 0; m_sel = 0;
        o_frame = 0; o_pat = 0; o_sel = 0;
        ss_select = 8'hFF;
        ss_value  = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        m_bcd = '0; m_dots = '0; m_seen = '0;
        last_in = 16'hFFFF;
        run_len = 1000;
        #1;
        check_eq("init_bcd", bcd, 32'h0);
        check_eq("init_seen", 32'(digit_seen), 32'h0);

        // some captures, then reset with the clock stopped
        drive_seg(8'hFE, enc(5, 1), 4);
        drive_seg(8'hFD, enc(12, 0), 4);
        do_reset(1'b1);
        drive_seg(8'hFF, 8'hFF, 3);

        // full scan 8..1 with DP on digits 0 and 7
        for (int k = 0; k < 8; k++)
            drive_seg(~(8'h01 << k), enc(8 - k, (k == 0) || (k == 7)), 4);
        check_eq("scan_bcd", bcd, 32'h12345678);
        check_eq("scan_dots", 32'(dots), 32'h81);
        check_eq("scan_frames", o_frame, 1);

        // one-cycle glitch on digit 3 must not capture
        drive_seg(8'hF7, enc(5, 0), 1);
        drive_seg(8'hFF, 8'hFF, 4);
        check_eq("glitch_bcd", bcd, 32'h12345678);

        // blank-ish pattern 09 on digit 2
        drive_seg(8'hFB, 8'hF6, 4);
        check_eq("bad_pat_seen2", 32'(digit_seen[2]), 32'h0);

        // two select lines low, then idle
        drive_seg(8'hF3, enc(1, 0), 4);
        drive_seg(8'hFF, 8'hFF, 4);
        check_eq("multi_sel_cnt", o_sel, 1);

        // partial frame, reset, then a full FEDCBA90 scan
        for (int k = 0; k < 5; k++) drive_seg(~(8'h01 << k), enc(k + 1, 0), 4);
        do_reset(1'b0);
        for (int k = 0; k < 8; k++)
            drive_seg(~(8'h01 << k), enc((k == 0) ? 0 : k + 8, 0), 4);
        check_eq("reset_scan_bcd", bcd, 32'hFEDCBA90);
        check_eq("reset_scan_frames", o_frame, 2);

        // random bus traffic
        for (int t = 0; t < 200; t++) begin
            do begin
                case ($urandom_range(0, 9))
                    0:       rs = 8'hFF;
                    1, 2:    rs = 8'($urandom);
                    default: rs = ~(8'h01 << $urandom_range(0, 7));
                endcase
                if ($urandom_range(0, 9) < 7) rv = enc($urandom_range(0, 15), 1'($urandom));
                else                          rv = 8'($urandom);
            end while ({rs, rv} == last_in);
            hold = ($urandom_range(0, 3) == 0) ? 1 : 4;
            drive_seg(rs, rv, hold);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
